// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store has fixed priority; fetch is forced to win after MAX_WAIT denied cycles.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LAT      = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int LCW = $clog2(LAT + 1);
  localparam int SCW = $clog2(MAX_WAIT + 1);
  localparam logic [LCW-1:0] LAT_C  = LCW'(LAT);
  localparam logic [LCW-1:0] LAT_M1 = LCW'(LAT - 1);
  localparam logic [SCW-1:0] MAX_C  = SCW'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  state_t         r_state;
  owner_t         r_owner;
  logic [LCW-1:0] r_lat_cnt;
  logic [SCW-1:0] r_starve_cnt;
  logic           r_if_rvalid;
  logic           r_ls_rvalid;

  logic w_can_gnt;
  logic w_if_win;
  logic w_ls_win;
  logic w_rd_gnt;
  logic w_if_rv_d;
  logic w_ls_rv_d;

  // A grant may coincide with the cycle the outstanding read returns.
  assign w_can_gnt = RST_X && ((r_state == S_IDLE) || (r_lat_cnt == LAT_C));
  assign w_if_win  = w_can_gnt && if_req && ((r_starve_cnt == MAX_C) || !ls_req);
  assign w_ls_win  = w_can_gnt && ls_req && !w_if_win;
  assign w_rd_gnt  = w_if_win || (w_ls_win && !ls_we);

  assign if_gnt    = w_if_win;
  assign ls_gnt    = w_ls_win;
  assign m_en      = w_if_win || w_ls_win;
  assign m_we      = w_ls_win && ls_we;
  assign m_addr    = w_if_win ? if_addr : (w_ls_win ? ls_addr : '0);
  assign m_wdata   = (w_ls_win && ls_we) ? ls_wdata : '0;
  assign if_rdata  = m_rdata;
  assign ls_rdata  = m_rdata;
  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_if_rv_d = 1'b0;
    w_ls_rv_d = 1'b0;
    if (LAT == 1) begin
      w_if_rv_d = w_if_win;
      w_ls_rv_d = w_ls_win && !ls_we;
    end else if (r_lat_cnt == LAT_M1) begin
      w_if_rv_d = (r_owner == OWN_IF);
      w_ls_rv_d = (r_owner == OWN_LS);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_if_rvalid  <= 1'b0;
      r_ls_rvalid  <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_rv_d;
      r_ls_rvalid <= w_ls_rv_d;

      if (w_rd_gnt) begin
        r_owner   <= w_if_win ? OWN_IF : OWN_LS;
        r_lat_cnt <= LCW'(1);
        r_state   <= (LAT > 1) ? S_BUSY : S_IDLE;
      end else if ((r_owner != OWN_NONE) && (r_lat_cnt == LAT_C)) begin
        r_owner   <= OWN_NONE;
        r_lat_cnt <= '0;
        r_state   <= S_IDLE;
      end else if (r_owner != OWN_NONE) begin
        r_lat_cnt <= r_lat_cnt + LCW'(1);
      end

      if (if_req && !w_if_win) begin
        if (r_starve_cnt != MAX_C) r_starve_cnt <= r_starve_cnt + SCW'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule
